// File: rtl/note_period_scheduler_pkg.sv
// Shared types and elaboration-time helpers for the note period scheduler:
// note codes, FSM states, the note frequency table and the period window bounds.
package note_pkg;

  typedef enum logic [3:0] {
    NOTE_C  = 4'd0,
    NOTE_CS = 4'd1,
    NOTE_D  = 4'd2,
    NOTE_DS = 4'd3,
    NOTE_E  = 4'd4,
    NOTE_F  = 4'd5,
    NOTE_FS = 4'd6,
    NOTE_G  = 4'd7,
    NOTE_GS = 4'd8,
    NOTE_A  = 4'd9,
    NOTE_AS = 4'd10,
    NOTE_B  = 4'd11,
    NO_NOTE = 4'd15
  } note_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    MEASURE,
    SEARCH,
    FILTER,
    OUTPUT
  } state_t;

  localparam int unsigned NUM_NOTES = 12;
  localparam int unsigned NUM_OCT   = 3;

  // Base-octave note frequencies in units of 0.01 Hz (C4 .. B4).
  function automatic int unsigned freq_100(input int unsigned idx);
    case (idx)
      0:       return 26163;
      1:       return 27718;
      2:       return 29366;
      3:       return 31113;
      4:       return 32963;
      5:       return 34923;
      6:       return 36999;
      7:       return 39200;
      8:       return 41530;
      9:       return 44000;
      10:      return 46616;
      default: return 49388;
    endcase
  endfunction

  // Lower edge of the period window: 96 % of the nominal period in clk cycles.
  function automatic int unsigned low_bound(input int unsigned clk_mhz,
                                            input int unsigned f100,
                                            input int unsigned o);
    return ((clk_mhz * 32'd1000000) / (f100 << o)) * 32'd96;
  endfunction

  // Upper edge of the period window: 104 % of the nominal period in clk cycles.
  function automatic int unsigned high_bound(input int unsigned clk_mhz,
                                             input int unsigned f100,
                                             input int unsigned o);
    return ((clk_mhz * 32'd1000000) / (f100 << o)) * 32'd104;
  endfunction

endpackage

// File: rtl/note_period_scheduler_bound_table.sv
// Combinational lookup of the {low, high} period window for one candidate
// {note index, octave}. All entries are constants elaborated from note_pkg.
module note_bound_table
  import note_pkg::*;
#(
  parameter int unsigned CLK_MHZ = 50
) (
  input  logic [3:0]  idx,
  input  logic [1:0]  oct,
  output logic [31:0] low,
  output logic [31:0] high
);

  localparam int unsigned ENTRIES = NUM_NOTES * NUM_OCT;

  logic [31:0] low_tab  [ENTRIES];
  logic [31:0] high_tab [ENTRIES];
  logic [5:0]  sel;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    assign low_tab[g]  = low_bound(CLK_MHZ, freq_100(g % NUM_NOTES), g / NUM_NOTES);
    assign high_tab[g] = high_bound(CLK_MHZ, freq_100(g % NUM_NOTES), g / NUM_NOTES);
  end

  assign sel = 6'(idx) + 6'(oct) * 6'd12;

  // Select the window for the current candidate; out-of-table indices give an empty window.
  always_comb begin
    low  = '0;
    high = '0;
    if (idx < 4'(NUM_NOTES) && oct < 2'(NUM_OCT)) begin
      low  = low_tab[sel];
      high = high_tab[sel];
    end
  end

endmodule

// File: rtl/note_period_scheduler.sv
// Pitch measurement controller: locks onto rising threshold crossings of the
// mic sample, averages N_PERIODS periods, searches the note table one
// candidate per cycle, filters consecutive results and reports stable notes
// over a valid/ready handshake.
// Optional feature macro: NOTE_SCHED_OCTAVE_EN (search octaves 0..2 and
// report the matching octave; otherwise only octave 0 is searched).
module note_period_scheduler
  import note_pkg::*;
#(
  parameter int unsigned        CLK_MHZ    = 50,
  parameter int unsigned        W_VAL      = 16,
  parameter logic [W_VAL-1:0]   THRESHOLD  = 16'h1100,
  parameter int unsigned        N_PERIODS  = 4,
  parameter logic [19:0]        TIMEOUT    = 20'hFFFFF,
  parameter int unsigned        STABLE_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W_VAL-1:0] sample,
  input  logic             run,
  output logic             note_valid,
  input  logic             note_ready,
  output logic [3:0]       note_code,
  output logic [1:0]       octave,
  output logic [19:0]      period_avg,
  output logic             busy
);

  localparam int unsigned LOG2N = $clog2(N_PERIODS);
  localparam int unsigned ACC_W = 20 + LOG2N;
  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
`ifdef NOTE_SCHED_OCTAVE_EN
  localparam logic [1:0] LAST_OCT = 2'd2;
`else
  localparam logic [1:0] LAST_OCT = 2'd0;
`endif

  state_t             state, state_next;
  logic [W_VAL-1:0]   prev_sample;
  logic               rise;
  logic [19:0]        per_cnt, per_inc;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [3:0]         k;
  logic [3:0]         cand_idx;
  logic [1:0]         cand_oct;
  logic [31:0]        low, high;
  logic               in_range, last_cand, meas_done, timed_out;
  logic [3:0]         res_code, prev_code, last_code;
  logic [1:0]         res_oct, prev_oct, last_oct;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               report;

  note_bound_table #(.CLK_MHZ(CLK_MHZ)) u_table (
    .idx  (cand_idx),
    .oct  (cand_oct),
    .low  (low),
    .high (high)
  );

  assign rise      = (sample >= THRESHOLD) && (prev_sample < THRESHOLD);
  assign per_inc   = (per_cnt == TIMEOUT) ? TIMEOUT : per_cnt + 20'd1;
  // per_cnt is cleared on a rise, so the incremented value is the full period length.
  assign acc_sum   = acc + ACC_W'(per_inc);
  assign meas_done = rise && (k == 4'(N_PERIODS - 1));
  assign timed_out = !rise && (per_cnt == TIMEOUT);
  assign in_range  = (32'(period_avg) > low) && (32'(period_avg) < high);
  assign last_cand = (cand_idx == 4'd11) && (cand_oct == LAST_OCT);
  assign busy      = (state != IDLE);

  // Consecutive-result filter: count saturates at STABLE_CNT, restarts at 1 on change.
  always_comb begin
    cnt_next = CNT_W'(1);
    if ({res_code, res_oct} == {prev_code, prev_oct})
      cnt_next = (cnt == CNT_W'(STABLE_CNT)) ? cnt : cnt + CNT_W'(1);
    report = (cnt_next >= CNT_W'(STABLE_CNT)) &&
             ({res_code, res_oct} != {last_code, last_oct});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; run=0 aborts every state except an outstanding transfer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = SYNC;
      SYNC: begin
        if (!run)                        state_next = IDLE;
        else if (rise)                   state_next = MEASURE;
        else if (per_cnt == TIMEOUT)     state_next = FILTER;
      end
      MEASURE: begin
        if (!run)                        state_next = IDLE;
        else if (meas_done)              state_next = SEARCH;
        else if (timed_out)              state_next = FILTER;
      end
      SEARCH: begin
        if (!run)                        state_next = IDLE;
        else if (in_range || last_cand)  state_next = FILTER;
      end
      FILTER: begin
        if (!run)                        state_next = IDLE;
        else if (report)                 state_next = OUTPUT;
        else                             state_next = SYNC;
      end
      OUTPUT:  if (note_ready) state_next = run ? SYNC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Measurement, search, filter and handshake datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample <= '0;
      per_cnt     <= '0;
      acc         <= '0;
      k           <= '0;
      cand_idx    <= '0;
      cand_oct    <= '0;
      res_code    <= NO_NOTE;
      res_oct     <= '0;
      prev_code   <= NO_NOTE;
      prev_oct    <= '0;
      last_code   <= NO_NOTE;
      last_oct    <= '0;
      cnt         <= '0;
      period_avg  <= '0;
      note_valid  <= 1'b0;
      note_code   <= NO_NOTE;
    end else begin
      prev_sample <= sample;
      per_cnt     <= '0;
      case (state)
        SYNC: if (run) begin
          if (rise) begin
            acc <= '0;
            k   <= '0;
          end else if (per_cnt == TIMEOUT) begin
            res_code   <= NO_NOTE;
            res_oct    <= '0;
            period_avg <= TIMEOUT;
          end else begin
            per_cnt <= per_inc;
          end
        end
        MEASURE: if (run) begin
          if (rise) begin
            acc <= acc_sum;
            k   <= k + 4'd1;
            if (meas_done) begin
              period_avg <= 20'(acc_sum >> LOG2N);
              cand_idx   <= '0;
              cand_oct   <= '0;
            end
          end else if (timed_out) begin
            res_code   <= NO_NOTE;
            res_oct    <= '0;
            period_avg <= TIMEOUT;
          end else begin
            per_cnt <= per_inc;
          end
        end
        SEARCH: if (run) begin
          if (in_range) begin
            res_code <= cand_idx;
            res_oct  <= cand_oct;
          end else if (last_cand) begin
            res_code <= NO_NOTE;
            res_oct  <= '0;
          end else if (cand_idx == 4'd11) begin
            cand_idx <= '0;
            cand_oct <= cand_oct + 2'd1;
          end else begin
            cand_idx <= cand_idx + 4'd1;
          end
        end
        FILTER: if (run) begin
          prev_code <= res_code;
          prev_oct  <= res_oct;
          cnt       <= cnt_next;
          if (report) begin
            note_valid <= 1'b1;
            note_code  <= res_code;
          end
        end
        OUTPUT: if (note_ready) begin
          note_valid <= 1'b0;
          last_code  <= res_code;
          last_oct   <= res_oct;
        end
        default: ;
      endcase
    end
  end

`ifdef NOTE_SCHED_OCTAVE_EN
  // Reported octave is captured together with the note code.
  always_ff @(posedge clk) begin
    if (reset)                                        octave <= '0;
    else if (state == FILTER && state_next == OUTPUT) octave <= res_oct;
  end
`else
  assign octave = 2'd0;
`endif

endmodule
